tdc_meas_ctrl: RTL and testbench

//   Measurement sequencer for the tapped-delay-line TDC. On a request it fires the

---
 rtl/tdc_pkg.sv | 18 +
 rtl/tdc_therm_enc.sv | 31 +++
 rtl/tdc_meas_ctrl.sv | 138 +++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement path.
//   TDC_N_DELAY : default delay-line length (thermometer code width)
//   CNT_W       : width needed to hold a tap count 0..TDC_N_DELAY
//   tdc_state_t : measurement sequencer states
package tdc_pkg;
   localparam int TDC_N_DELAY = 32;
   localparam int CNT_W       = $clog2(TDC_N_DELAY + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LAUNCH,
      SETTLE,
      CAPTURE,
      ENCODE,
      RESULT
   } tdc_state_t;
endpackage

// File: rtl/tdc_therm_enc.sv
// Thermometer-code encoder (purely combinational).
//   code   in  N        registered thermometer code, bit 0 nearest the launch point
//   count  out CW       number of ones in code
//   bubble out 1        some bit is set while the bit below it is clear
//   sat    out 1        code is all ones (edge ran off the end of the line)
module tdc_therm_enc
   import tdc_pkg::*;
#(
   parameter int N  = TDC_N_DELAY,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  code,
   output logic [CW-1:0] count,
   output logic          bubble,
   output logic          sat
);

   always_comb begin
      count  = '0;
      bubble = 1'b0;
      for (int i = 0; i < N; i++)
         count = count + CW'(code[i]);
      // A set bit above a clear bit means the code is not 0..01..1.
      for (int i = 1; i < N; i++)
         if (code[i] && !code[i-1])
            bubble = 1'b1;
   end

   assign sat = &code;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the tapped-delay-line TDC.
// Each shot: clear the line, raise the start edge, wait the settle time,
// capture the thermometer code, encode and accumulate it. After 2^avg_log2
// shots the mean tap count and OR-ed flags are offered on a valid/ready port.
//   clk, rst_n              clock; rst_n is an async reset, active HIGH
//   req                     start a burst (looked at in IDLE only)
//   avg_log2, settle_cyc    burst settings, latched when the burst is accepted
//   therm                   thermometer code from the delay line
//   tdc_start, tdc_clr      delay-line controls
//   busy                    sequencer not idle
//   res_valid/res_ready     result handshake
//   res_count, res_bubble, res_sat   averaged result and flags
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter int N_DELAY      = TDC_N_DELAY,
   parameter int MAX_AVG_LOG2 = 4,
   parameter int SETTLE_W     = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req,
   input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]  avg_log2,
   input  logic [SETTLE_W-1:0]                settle_cyc,
   input  logic [N_DELAY-1:0]                 therm,
   output logic                               tdc_start,
   output logic                               tdc_clr,
   output logic                               busy,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [$clog2(N_DELAY+1)-1:0]       res_count,
   output logic                               res_bubble,
   output logic                               res_sat
);

   localparam int CW     = $clog2(N_DELAY + 1);
   localparam int AW     = $clog2(MAX_AVG_LOG2 + 1);
   localparam int ACC_W  = CW + MAX_AVG_LOG2;
   localparam int SHOT_W = MAX_AVG_LOG2 + 1;

   tdc_state_t          state, nxt;
   logic [AW-1:0]       avg_q;
   logic [SETTLE_W-1:0] settle_q;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [SHOT_W-1:0]   shot_left;
   logic [N_DELAY-1:0]  code_q;
   logic [ACC_W-1:0]    acc;
   logic                bub_q;
   logic                sat_q;
   logic [CW-1:0]       enc_count;
   logic                enc_bub;
   logic                enc_sat;
   logic                accept;
   logic [AW-1:0]       avg_clamp;
   logic [SETTLE_W-1:0] settle_eff;

   assign accept     = (state == IDLE) && req;
   assign avg_clamp  = (avg_log2 > AW'(MAX_AVG_LOG2)) ? AW'(MAX_AVG_LOG2) : avg_log2;
   assign settle_eff = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;

   tdc_therm_enc #(.N(N_DELAY), .CW(CW)) u_enc (
      .code   (code_q),
      .count  (enc_count),
      .bubble (enc_bub),
      .sat    (enc_sat)
   );

   // state register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= nxt;
   end

   // next-state logic
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req) nxt = CLEAR;
         CLEAR:   nxt = LAUNCH;
         LAUNCH:  nxt = SETTLE;
         SETTLE:  if (settle_cnt == SETTLE_W'(1)) nxt = CAPTURE;
         CAPTURE: nxt = ENCODE;
         ENCODE:  nxt = (shot_left == '0) ? RESULT : CLEAR;
         RESULT:  if (res_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // outputs decoded from state; async reset forces them low immediately
   always_comb begin
      tdc_clr   = (state == CLEAR);
      tdc_start = (state == LAUNCH) || (state == SETTLE) || (state == CAPTURE);
      busy      = (state != IDLE);
      res_valid = (state == RESULT);
   end

   // datapath: burst settings, settle timer, shot counter, accumulator
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         avg_q      <= '0;
         settle_q   <= '0;
         settle_cnt <= '0;
         shot_left  <= '0;
         code_q     <= '0;
         acc        <= '0;
         bub_q      <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         if (accept) begin
            avg_q     <= avg_clamp;
            settle_q  <= settle_eff;
            // shots remaining after the current one
            shot_left <= SHOT_W'((32'd1 << avg_clamp) - 32'd1);
            acc       <= '0;
            bub_q     <= 1'b0;
            sat_q     <= 1'b0;
         end
         case (state)
            LAUNCH:  settle_cnt <= settle_q;
            SETTLE:  settle_cnt <= settle_cnt - SETTLE_W'(1);
            CAPTURE: code_q     <= therm;
            ENCODE: begin
               acc   <= acc + ACC_W'(enc_count);
               bub_q <= bub_q | enc_bub;
               sat_q <= sat_q | enc_sat;
               if (shot_left != '0) shot_left <= shot_left - SHOT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // mean of 2^avg_q shots always fits in CW bits
   assign res_count  = CW'(acc >> avg_q);
   assign res_bubble = bub_q;
   assign res_sat    = sat_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: directed table, randomized bursts
// against a reference model, handshake hold and mid-burst reset sequences.
module tb_tdc_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [2:0]  avg_log2;
   logic [3:0]  settle_cyc;
   logic [31:0] therm;
   logic        tdc_start, tdc_clr, busy, res_valid, res_ready;
   logic [5:0]  res_count;
   logic        res_bubble, res_sat;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tdc_meas_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .avg_log2   (avg_log2),
      .settle_cyc (settle_cyc),
      .therm      (therm),
      .tdc_start  (tdc_start),
      .tdc_clr    (tdc_clr),
      .busy       (busy),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_count  (res_count),
      .res_bubble (res_bubble),
      .res_sat    (res_sat)
   );

   typedef struct {
      logic [2:0]        avg;
      logic [3:0]        st;
      logic [15:0][31:0] codes;
      int                cnt;
      bit                bub;
      bit                sat;
      int                lat;
      bit                rdy;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: mean of popcounts, bubble = code not of form 2^k-1, sat = all ones.
   task automatic model(input logic [2:0] avg, input logic [3:0] st,
                        input logic [15:0][31:0] codes,
                        output int cnt, output bit bub, output bit sat, output int lat);
      int n, shots, sum;
      n     = (avg > 3'd4) ? 4 : int'(avg);
      shots = 1 << n;
      sum   = 0;
      bub   = 0;
      sat   = 0;
      for (int k = 0; k < shots; k++) begin
         sum += $countones(codes[k]);
         if (((codes[k] + 32'd1) & codes[k]) != 32'd0) bub = 1;
         if (codes[k] == 32'hFFFF_FFFF) sat = 1;
      end
      cnt = sum >> n;
      lat = shots * (4 + ((st == 4'd0) ? 1 : int'(st)));
   endtask

   task automatic run_burst(input string tag, input logic [2:0] avg, input logic [3:0] st,
                            input logic [15:0][31:0] codes, input bit rdy,
                            input int ecnt, input bit ebub, input bit esat, input int elat);
      int  shot, cyc;
      bit  done;
      logic [5:0] snap_cnt;
      logic snap_b, snap_s, stable;
      @(negedge clk);
      avg_log2 = avg; settle_cyc = st; res_ready = rdy; req = 1'b1;
      @(posedge clk);
      shot = 0; cyc = 0; done = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         if (res_valid) begin
            req  = 1'b0;
            done = 1;
         end else begin
            cyc++;
            if (tdc_clr) begin
               if (shot < 16) therm = codes[shot];
               shot++;
            end
            // settings and req wiggle during the burst must be ignored
            req        = 1'($urandom_range(0, 1));
            avg_log2   = 3'($urandom);
            settle_cyc = 4'($urandom);
         end
      end
      chk({tag, "_latency"}, done ? cyc : -1, elat);
      chk({tag, "_count"}, res_count, ecnt);
      chk({tag, "_bubble"}, res_bubble, ebub);
      chk({tag, "_sat"}, res_sat, esat);
      if (!rdy) begin
         snap_cnt = res_count; snap_b = res_bubble; snap_s = res_sat;
         repeat (10) begin
            @(negedge clk);
            stable = res_valid && busy && (res_count == snap_cnt) &&
                     (res_bubble == snap_b) && (res_sat == snap_s);
            chk({tag, "_hold_stable"}, stable, 1);
            req = 1'($urandom_range(0, 1));
         end
         req = 1'b0;
         res_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_valid"}, res_valid, 0);
   endtask

   vec_t tbl[8];

   initial begin
      int cnt, lat, nclr, cyc;
      bit bub, sat;
      logic [15:0][31:0] codes;
      logic [2:0] ravg;
      logic [3:0] rst_v;
      int kk;

      for (int i = 0; i < 8; i++) tbl[i].codes = '0;
      tbl[0].avg = 0; tbl[0].st = 2;  tbl[0].codes[0] = 32'h0000_00FF;
      tbl[0].cnt = 8;  tbl[0].bub = 0; tbl[0].sat = 0; tbl[0].lat = 6;   tbl[0].rdy = 1;
      tbl[1].avg = 2; tbl[1].st = 3;
      tbl[1].codes[0] = 32'h0F; tbl[1].codes[1] = 32'hFF; tbl[1].codes[2] = 32'h3F; tbl[1].codes[3] = 32'h03;
      tbl[1].cnt = 5;  tbl[1].bub = 0; tbl[1].sat = 0; tbl[1].lat = 28;  tbl[1].rdy = 0;
      tbl[2].avg = 0; tbl[2].st = 1;  tbl[2].codes[0] = 32'h0000_00F7;
      tbl[2].cnt = 7;  tbl[2].bub = 1; tbl[2].sat = 0; tbl[2].lat = 5;   tbl[2].rdy = 1;
      tbl[3].avg = 0; tbl[3].st = 1;  tbl[3].codes[0] = 32'hFFFF_FFFF;
      tbl[3].cnt = 32; tbl[3].bub = 0; tbl[3].sat = 1; tbl[3].lat = 5;   tbl[3].rdy = 1;
      tbl[4].avg = 0; tbl[4].st = 0;  tbl[4].codes[0] = 32'h0000_0001;
      tbl[4].cnt = 1;  tbl[4].bub = 0; tbl[4].sat = 0; tbl[4].lat = 5;   tbl[4].rdy = 1;
      tbl[5].avg = 7; tbl[5].st = 1;
      for (int k = 0; k < 16; k++) tbl[5].codes[k] = 32'h0000_FFFF;
      tbl[5].cnt = 16; tbl[5].bub = 0; tbl[5].sat = 0; tbl[5].lat = 80;  tbl[5].rdy = 0;
      tbl[6].avg = 1; tbl[6].st = 4;  tbl[6].codes[0] = 32'h7; tbl[6].codes[1] = 32'h0;
      tbl[6].cnt = 1;  tbl[6].bub = 0; tbl[6].sat = 0; tbl[6].lat = 16;  tbl[6].rdy = 1;
      tbl[7].avg = 3; tbl[7].st = 15; tbl[7].codes[0] = 32'h8000_0000;
      for (int k = 1; k < 8; k++) tbl[7].codes[k] = 32'h0000_000F;
      tbl[7].cnt = 3;  tbl[7].bub = 1; tbl[7].sat = 0; tbl[7].lat = 152; tbl[7].rdy = 1;

      rst_n = 1'b1; req = 1'b0; avg_log2 = '0; settle_cyc = '0; therm = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tdc_start", tdc_start, 0);
      chk("rst_tdc_clr", tdc_clr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_res_bubble", res_bubble, 0);
      chk("rst_res_sat", res_sat, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_burst($sformatf("tbl%0d", i), tbl[i].avg, tbl[i].st, tbl[i].codes, tbl[i].rdy,
                   tbl[i].cnt, tbl[i].bub, tbl[i].sat, tbl[i].lat);

      for (int r = 0; r < 24; r++) begin
         for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
               0: begin
                  kk = $urandom_range(0, 32);
                  codes[k] = (kk == 32) ? 32'hFFFF_FFFF : ((32'd1 << kk) - 32'd1);
               end
               1: codes[k] = 32'hFFFF_FFFF;
               default: codes[k] = $urandom;
            endcase
         end
         ravg  = 3'($urandom);
         rst_v = 4'($urandom);
         model(ravg, rst_v, codes, cnt, bub, sat, lat);
         run_burst($sformatf("rnd%0d", r), ravg, rst_v, codes, 1'($urandom_range(0, 1)),
                   cnt, bub, sat, lat);
      end

      // reset during SETTLE of shot 2 of 4
      @(negedge clk);
      avg_log2 = 3'd2; settle_cyc = 4'd5; therm = 32'hFF; res_ready = 1'b1; req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      nclr = 0; cyc = 0;
      while (nclr < 2 && cyc < 200) begin
         if (tdc_clr) nclr++;
         if (nclr < 2) begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("mid_reach_shot2", nclr, 2);
      repeat (3) @(negedge clk);
      chk("mid_in_settle_start", tdc_start, 1);
      chk("mid_in_settle_busy", busy, 1);
      #2 rst_n = 1'b1;
      #1;
      chk("mid_rst_tdc_start", tdc_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_count", res_count, 0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_valid", res_valid, 0);
      end
      rst_n = 1'b0;
      codes = '0;
      codes[0] = 32'h3; codes[1] = 32'h5;
      run_burst("after_rst", 3'd1, 4'd2, codes, 1'b1, 2, 1'b1, 1'b0, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
